// File: rtl/dlfloat_pkg.sv
// rtl/dlfloat_pkg.sv - shared DLFloat constants and sequencer state type
package dlfloat_pkg;

    localparam int DLF_W = 16;
    localparam logic [DLF_W-1:0] DLF_ZERO = 16'h0000;
    localparam logic [DLF_W-1:0] DLF_ONE  = 16'h3E00;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_A,
        LOAD_B,
        DRAIN,
        DONE
    } seq_state_t;

endpackage

// File: rtl/dlfloat_mac_sequencer_if.sv
// rtl/dlfloat_mac_sequencer_if.sv - operand, MAC and result handshake bundle of the sequencer
interface dlfloat_mac_sequencer_if
    import dlfloat_pkg::*;
#(
    parameter int DW    = DLF_W,
    parameter int CNT_W = 8
);

    logic             start;
    logic [CNT_W-1:0] cfg_len;
    logic             abort;
    logic [DW-1:0]    in_data;
    logic             in_valid;
    logic             in_ready;
    logic [DW-1:0]    mac_a;
    logic [DW-1:0]    mac_b;
    logic             mac_en;
    logic             mac_clr;
    logic [DW-1:0]    mac_c;
    logic [DW-1:0]    res_data;
    logic             res_valid;
    logic             res_ready;
    logic             busy;

    // master = host plus MAC side, slave = the sequencer
    modport master (
        output start, cfg_len, abort, in_data, in_valid, mac_c, res_ready,
        input  in_ready, mac_a, mac_b, mac_en, mac_clr, res_data, res_valid, busy
    );

    modport slave (
        input  start, cfg_len, abort, in_data, in_valid, mac_c, res_ready,
        output in_ready, mac_a, mac_b, mac_en, mac_clr, res_data, res_valid, busy
    );

endinterface

// File: rtl/dlfloat_drain_timer.sv
// rtl/dlfloat_drain_timer.sv - loadable down-counter that flags when the MAC pipeline has drained
module dlfloat_drain_timer #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         expired
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign expired = (cnt == '0);

endmodule

// File: rtl/dlfloat_mac_sequencer.sv
// rtl/dlfloat_mac_sequencer.sv - feeds N operand pairs to the DLFloat MAC, drains it, returns the sum
module dlfloat_mac_sequencer
    import dlfloat_pkg::*;
#(
    parameter int DW      = DLF_W,
    parameter int CNT_W   = 8,
    parameter int MAC_LAT = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    dlfloat_mac_sequencer_if.slave  bus
);

    localparam int TW = $clog2(MAC_LAT + 1);

    seq_state_t       state;
    logic [CNT_W-1:0] len;
    logic [CNT_W-1:0] pair_cnt;
    logic [DW-1:0]    a_hold;
    logic             in_hs;
    logic             last_pair;
    logic             drain_load;
    logic             drain_expired;

    assign bus.in_ready = (state == LOAD_A) || (state == LOAD_B);
    assign bus.busy     = (state != IDLE);

    assign in_hs     = bus.in_valid && bus.in_ready;
    assign last_pair = (pair_cnt == len - 1'b1);
    // abort outranks the final pair, so the timer must not be armed then
    assign drain_load = (state == LOAD_B) && in_hs && last_pair && !bus.abort;

    dlfloat_drain_timer #(
        .W (TW)
    ) u_drain_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (drain_load),
        .load_val (TW'(MAC_LAT)),
        .dec      (state == DRAIN),
        .expired  (drain_expired)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            len           <= '0;
            pair_cnt      <= '0;
            a_hold        <= '0;
            bus.mac_a     <= '0;
            bus.mac_b     <= '0;
            bus.mac_en    <= 1'b0;
            bus.mac_clr   <= 1'b0;
            bus.res_data  <= '0;
            bus.res_valid <= 1'b0;
        end else begin
            bus.mac_en  <= 1'b0;
            bus.mac_clr <= 1'b0;
            if ((state != IDLE) && bus.abort) begin
                bus.mac_clr   <= 1'b1;
                bus.res_valid <= 1'b0;
                pair_cnt      <= '0;
                state         <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (bus.start && !bus.abort) begin
                            len      <= bus.cfg_len;
                            pair_cnt <= '0;
                            if (bus.cfg_len != '0) begin
                                state <= LOAD_A;
                            end else begin
                                bus.res_data  <= DW'(DLF_ZERO);
                                bus.res_valid <= 1'b1;
                                state         <= DONE;
                            end
                        end
                    end
                    LOAD_A: begin
                        if (in_hs) begin
                            a_hold <= bus.in_data;
                            state  <= LOAD_B;
                        end
                    end
                    LOAD_B: begin
                        if (in_hs) begin
                            bus.mac_a  <= a_hold;
                            bus.mac_b  <= bus.in_data;
                            bus.mac_en <= 1'b1;
                            pair_cnt   <= pair_cnt + 1'b1;
                            state      <= last_pair ? DRAIN : LOAD_A;
                        end
                    end
                    DRAIN: begin
                        if (drain_expired) begin
                            bus.res_data  <= bus.mac_c;
                            bus.res_valid <= 1'b1;
                            state         <= DONE;
                        end
                    end
                    DONE: begin
                        if (bus.res_ready) begin
                            bus.res_valid <= 1'b0;
                            bus.mac_clr   <= 1'b1;
                            state         <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_dlfloat_mac_sequencer.sv
// tb/tb_dlfloat_mac_sequencer.sv - directed bench for the sequencer with a behavioural 3-cycle MAC
module tb_dlfloat_mac_sequencer;
    import dlfloat_pkg::*;

    localparam int DW      = 16;
    localparam int CNT_W   = 8;
    localparam int MAC_LAT = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dlfloat_mac_sequencer_if #(.DW(DW), .CNT_W(CNT_W)) bus ();

    dlfloat_mac_sequencer #(
        .DW      (DW),
        .CNT_W   (CNT_W),
        .MAC_LAT (MAC_LAT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    function automatic real dlf_to_real(input logic [15:0] w);
        real v;
        int  e;
        if (w[14:0] == 15'd0) return 0.0;
        v = 1.0 + real'(w[8:0]) / 512.0;
        e = int'(w[14:9]) - 31;
        while (e > 0) begin v = v * 2.0; e--; end
        while (e < 0) begin v = v / 2.0; e++; end
        return w[15] ? -v : v;
    endfunction

    function automatic logic [15:0] real_to_dlf(input real x);
        real v;
        int  e;
        int  m;
        logic s;
        if (x == 0.0) return 16'h0000;
        s = (x < 0.0);
        v = s ? -x : x;
        e = 31;
        while (v >= 2.0) begin v = v / 2.0; e++; end
        while (v < 1.0) begin v = v * 2.0; e--; end
        m = int'((v - 1.0) * 512.0);
        return {s, e[5:0], m[8:0]};
    endfunction

    // behavioural MAC: product enters at mac_en, lands in the accumulator MAC_LAT cycles later
    real  acc, p1_prod, p2_prod;
    logic p1_en, p2_en;
    always @(posedge clk or posedge rst) begin
        if (rst || bus.mac_clr) begin
            acc <= 0.0; p1_prod <= 0.0; p2_prod <= 0.0; p1_en <= 1'b0; p2_en <= 1'b0;
        end else begin
            p1_en   <= bus.mac_en;
            p1_prod <= dlf_to_real(bus.mac_a) * dlf_to_real(bus.mac_b);
            p2_en   <= p1_en;
            p2_prod <= p1_prod;
            if (p2_en) acc <= acc + p2_prod;
        end
    end
    assign bus.mac_c = real_to_dlf(acc);

    int          cyc = 0;
    int          en_count = 0;
    int          rv_rises = 0;
    int          last_en_cyc = 0;
    int          rv_rise_cyc = 0;
    logic        rv_prev = 1'b0;
    logic [15:0] last_a = '0;
    logic [15:0] last_b = '0;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        if (bus.mac_en) begin
            en_count++;
            last_en_cyc = cyc;
            last_a = bus.mac_a;
            last_b = bus.mac_b;
        end
        if (bus.res_valid && !rv_prev) begin
            rv_rises++;
            rv_rise_cyc = cyc;
        end
        rv_prev = bus.res_valid;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_op(input logic [7:0] n);
        bus.cfg_len = n;
        bus.start   = 1'b1;
        step();
        bus.start   = 1'b0;
    endtask

    task automatic send(input logic [15:0] w, input int gap);
        int guard;
        guard       = 0;
        bus.in_data = w;
        bus.in_valid = 1'b1;
        while (!bus.in_ready && guard < 50) begin step(); guard++; end
        if (!bus.in_ready) chk("in_ready_timeout", 32'(bus.in_ready), 32'd1);
        step();
        bus.in_valid = 1'b0;
        repeat (gap) step();
    endtask

    task automatic wait_res();
        int guard;
        guard = 0;
        while (!bus.res_valid && guard < 600) begin step(); guard++; end
        chk("res_valid_timeout", 32'(bus.res_valid), 32'd1);
        @(negedge clk);
        #1;
    endtask

    task automatic release_res();
        bus.res_ready = 1'b1;
        step();
        bus.res_ready = 1'b0;
        chk("mac_clr_pulse", 32'(bus.mac_clr), 32'd1);
        chk("res_valid_cleared", 32'(bus.res_valid), 32'd0);
        chk("busy_after_done", 32'(bus.busy), 32'd0);
        step();
        chk("mac_clr_one_cycle", 32'(bus.mac_clr), 32'd0);
    endtask

    typedef struct packed {
        logic [7:0]       len;
        logic [3:0][15:0] a;
        logic [3:0][15:0] b;
        logic [7:0]       gap;
        logic [15:0]      exp_res;
    } vec_t;

    vec_t        vecs [4];
    int          en0, rv0, idx;
    logic [15:0] hold_d;

    initial begin
        // 1.0*2.0 = 2.0; 3 x 1.0 = 3.0 (0x4100); 2*2+1*2 = 6.0 (0x4300); 255 x (1.0*0) = 0
        vecs[0] = '{len: 8'd1,   a: {4{DLF_ONE}}, b: {4{16'h4000}}, gap: 8'd0, exp_res: 16'h4000};
        vecs[1] = '{len: 8'd3,   a: {4{DLF_ONE}}, b: {4{DLF_ONE}},   gap: 8'd2, exp_res: 16'h4100};
        vecs[2] = '{len: 8'd2,   a: {16'h0, 16'h0, DLF_ONE, 16'h4000}, b: {4{16'h4000}},
                    gap: 8'd1, exp_res: 16'h4300};
        vecs[3] = '{len: 8'd255, a: {4{DLF_ONE}}, b: {4{DLF_ZERO}},  gap: 8'd0, exp_res: 16'h0000};

        bus.start = 1'b0; bus.cfg_len = '0; bus.abort = 1'b0;
        bus.in_data = '0; bus.in_valid = 1'b0; bus.res_ready = 1'b0;
        step(); step();
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
        chk("rst_res_valid", 32'(bus.res_valid), 32'd0);
        chk("rst_mac_en", 32'(bus.mac_en), 32'd0);
        chk("rst_mac_clr", 32'(bus.mac_clr), 32'd0);
        rst = 1'b0;
        step();

        for (int v = 0; v < 4; v++) begin
            en0 = en_count;
            start_op(vecs[v].len);
            chk("busy_after_start", 32'(bus.busy), 32'd1);
            for (int p = 0; p < int'(vecs[v].len); p++) begin
                send(vecs[v].a[p % 4], int'(vecs[v].gap));
                send(vecs[v].b[p % 4], int'(vecs[v].gap));
            end
            wait_res();
            idx = (int'(vecs[v].len) - 1) % 4;
            chk("res_data", 32'(bus.res_data), 32'(vecs[v].exp_res));
            chk("mac_en_count", 32'(en_count - en0), 32'(vecs[v].len));
            chk("res_latency", 32'(rv_rise_cyc - last_en_cyc), 32'(MAC_LAT + 1));
            chk("last_mac_a", 32'(last_a), 32'(vecs[v].a[idx]));
            chk("last_mac_b", 32'(last_b), 32'(vecs[v].b[idx]));
            chk("done_in_ready", 32'(bus.in_ready), 32'd0);
            release_res();
        end

        // zero-length vector
        en0 = en_count;
        start_op(8'd0);
        chk("len0_res_valid", 32'(bus.res_valid), 32'd1);
        chk("len0_res_data", 32'(bus.res_data), 32'h0);
        chk("len0_busy", 32'(bus.busy), 32'd1);
        repeat (3) step();
        chk("len0_busy_held", 32'(bus.busy), 32'd1);
        chk("len0_no_mac_en", 32'(en_count - en0), 32'd0);
        release_res();

        // result held while consumer stalls; start in DONE ignored
        start_op(8'd1);
        send(DLF_ONE, 0);
        send(16'h4000, 0);
        wait_res();
        hold_d = bus.res_data;
        chk("hold_res_data", 32'(hold_d), 32'h4000);
        bus.cfg_len = 8'd5;
        for (int i = 0; i < 10; i++) begin
            bus.start = (i == 3);
            step();
            chk("hold_res_valid", 32'(bus.res_valid), 32'd1);
            chk("hold_res_stable", 32'(bus.res_data), 32'(hold_d));
            chk("hold_in_ready", 32'(bus.in_ready), 32'd0);
        end
        bus.start = 1'b0;
        release_res();

        // abort after the first pair of four
        rv0 = rv_rises;
        start_op(8'd4);
        send(DLF_ONE, 0);
        send(16'h4000, 0);
        chk("abort_mac_en_seen", 32'(bus.mac_en), 32'd1);
        bus.abort = 1'b1;
        step();
        bus.abort = 1'b0;
        chk("abort_mac_clr", 32'(bus.mac_clr), 32'd1);
        chk("abort_busy", 32'(bus.busy), 32'd0);
        chk("abort_res_valid", 32'(bus.res_valid), 32'd0);
        repeat (10) step();
        chk("abort_no_result", 32'(rv_rises - rv0), 32'd0);
        bus.abort = 1'b1; bus.start = 1'b1; bus.cfg_len = 8'd1;
        step();
        bus.abort = 1'b0; bus.start = 1'b0;
        chk("abort_beats_start", 32'(bus.busy), 32'd0);
        start_op(8'd1);
        send(16'h4000, 0);
        send(16'h4000, 0);
        wait_res();
        chk("after_abort_res", 32'(bus.res_data), 32'h4200);
        release_res();

        // asynchronous reset in the middle of DRAIN
        start_op(8'd1);
        send(DLF_ONE, 0);
        send(16'h4000, 0);
        step();
        #2 rst = 1'b1;
        #1;
        chk("arst_mac_a", 32'(bus.mac_a), 32'h0);
        chk("arst_mac_b", 32'(bus.mac_b), 32'h0);
        chk("arst_mac_en", 32'(bus.mac_en), 32'd0);
        chk("arst_mac_clr", 32'(bus.mac_clr), 32'd0);
        chk("arst_res_valid", 32'(bus.res_valid), 32'd0);
        chk("arst_res_data", 32'(bus.res_data), 32'h0);
        chk("arst_busy", 32'(bus.busy), 32'd0);
        chk("arst_in_ready", 32'(bus.in_ready), 32'd0);
        step();
        rst = 1'b0;
        step();
        chk("post_rst_busy", 32'(bus.busy), 32'd0);
        chk("post_rst_in_ready", 32'(bus.in_ready), 32'd0);
        chk("post_rst_res_valid", 32'(bus.res_valid), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
